// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Tomasulo reorder buffer for the out-of-order RV32I core.
//               Allocates one tag per issued instruction at the tail,
//               captures results from two CDB ports, answers reservation
//               station operand lookups and retires completed entries in
//               program order from the head, at most one per cycle.
//
//               Ports:
//                 clock, reset              - clock, synchronous active-high reset
//                 alloc_valid/alloc_dest    - issue request and its destination
//                 alloc_ready/alloc_tag     - room available / tag handed out
//                 CDBiscast/CDBrobNum/CDBdata      - CDB port 1
//                 CDBiscast2/CDBrobNum2/CDBdata2   - CDB port 2
//                 index -> ready/value      - operand lookup
//                 commit_valid/tag/dest/data - registered retire outputs
//
//               Optional feature macro: ROB_CDB_BYPASS_EN
//                 When defined, the operand lookup also forwards the CDB
//                 results presented in the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH       = 16,
    parameter int TAG_W       = 6,
    parameter int INVALID_TAG = 16,
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              CDBiscast,
    input  logic [TAG_W-1:0]  CDBrobNum,
    input  logic [DATA_W-1:0] CDBdata,
    input  logic              CDBiscast2,
    input  logic [TAG_W-1:0]  CDBrobNum2,
    input  logic [DATA_W-1:0] CDBdata2,
    input  logic [TAG_W-1:0]  index,
    output logic              ready,
    output logic [DATA_W-1:0] value,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_data
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [TAG_W-1:0]   c_DEPTH_TAG = TAG_W'(DEPTH);
    localparam logic [TAG_W-1:0]   c_INVALID   = TAG_W'(INVALID_TAG);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    // Per-entry state
    logic [DEPTH-1:0]   r_busy;
    logic [DEPTH-1:0]   r_done;
    logic [REG_W-1:0]   r_dest [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               r_commit_valid;
    logic [TAG_W-1:0]   r_commit_tag;
    logic [REG_W-1:0]   r_commit_dest;
    logic [DATA_W-1:0]  r_commit_data;

    logic               w_alloc_fire;
    logic               w_commit_fire;
    logic [c_PTR_W-1:0] w_head_next;
    logic [c_PTR_W-1:0] w_tail_next;
    logic [c_PTR_W-1:0] w_cdb1_ptr;
    logic [c_PTR_W-1:0] w_cdb2_ptr;
    logic [c_PTR_W-1:0] w_idx_ptr;
    logic               w_cdb1_hit;
    logic               w_cdb2_hit;
    logic               w_idx_in_range;

    assign w_cdb1_ptr     = CDBrobNum[c_PTR_W-1:0];
    assign w_cdb2_ptr     = CDBrobNum2[c_PTR_W-1:0];
    assign w_idx_ptr      = index[c_PTR_W-1:0];
    assign w_idx_in_range = (index < c_DEPTH_TAG);

    // Out-of-range tags are screened before the narrowed pointer is used.
    assign w_cdb1_hit = CDBiscast  && (CDBrobNum  < c_DEPTH_TAG) && r_busy[w_cdb1_ptr];
    assign w_cdb2_hit = CDBiscast2 && (CDBrobNum2 < c_DEPTH_TAG) && r_busy[w_cdb2_ptr];

    assign alloc_ready   = (r_count < c_DEPTH_CNT);
    assign alloc_tag     = alloc_ready ? TAG_W'(r_tail) : c_INVALID;
    assign w_alloc_fire  = alloc_valid && alloc_ready;
    assign w_commit_fire = r_busy[r_head] && r_done[r_head];

    assign w_head_next = (r_head == c_LAST_PTR) ? '0 : r_head + 1'b1;
    assign w_tail_next = (r_tail == c_LAST_PTR) ? '0 : r_tail + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy         <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_tag   <= c_INVALID;
            r_commit_dest  <= '0;
            r_commit_data  <= '0;
        end else begin
            // Port 2 is written first so port 1 overrides on a tag collision.
            if (w_cdb2_hit) begin
                r_done[w_cdb2_ptr] <= 1'b1;
                r_data[w_cdb2_ptr] <= CDBdata2;
            end
            if (w_cdb1_hit) begin
                r_done[w_cdb1_ptr] <= 1'b1;
                r_data[w_cdb1_ptr] <= CDBdata;
            end

            r_commit_valid <= w_commit_fire;
            if (w_commit_fire) begin
                r_commit_tag       <= TAG_W'(r_head);
                r_commit_dest      <= r_dest[r_head];
                r_commit_data      <= r_data[r_head];
                r_busy[r_head]     <= 1'b0;
                r_done[r_head]     <= 1'b0;
                r_head             <= w_head_next;
            end

            // Tail never equals a busy head here, since alloc is refused when full.
            if (w_alloc_fire) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_dest[r_tail] <= alloc_dest;
                r_data[r_tail] <= '0;
                r_tail         <= w_tail_next;
            end

            case ({w_alloc_fire, w_commit_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_tag   = r_commit_tag;
    assign commit_dest  = r_commit_dest;
    assign commit_data  = r_commit_data;

    // Operand lookup
    always_comb begin
        ready = 1'b0;
        value = '0;
        if (w_idx_in_range && r_busy[w_idx_ptr] && r_done[w_idx_ptr]) begin
            ready = 1'b1;
            value = r_data[w_idx_ptr];
        end
`ifdef ROB_CDB_BYPASS_EN
        // Same-cycle forwarding; port 1 is checked last so it takes priority.
        if (w_idx_in_range && r_busy[w_idx_ptr]) begin
            if (CDBiscast2 && (CDBrobNum2 == index)) begin
                ready = 1'b1;
                value = CDBdata2;
            end
            if (CDBiscast && (CDBrobNum == index)) begin
                ready = 1'b1;
                value = CDBdata;
            end
        end
`else
        // Lookup reflects registered state only; CDB results appear a cycle later.
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. Directed stimulus
//               pushes expected retirements into a scoreboard queue; an
//               independent monitor pops and compares on every commit pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

`ifdef ROB_CDB_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic        alloc_ready;
    logic [5:0]  alloc_tag;
    logic        CDBiscast;
    logic [5:0]  CDBrobNum;
    logic [31:0] CDBdata;
    logic        CDBiscast2;
    logic [5:0]  CDBrobNum2;
    logic [31:0] CDBdata2;
    logic [5:0]  index;
    logic        ready;
    logic [31:0] value;
    logic        commit_valid;
    logic [5:0]  commit_tag;
    logic [4:0]  commit_dest;
    logic [31:0] commit_data;

    typedef struct packed {
        logic [5:0]  tag;
        logic [4:0]  dest;
        logic [31:0] data;
    } commit_t;

    commit_t sb[$];
    int      total;
    int      bad;

    reorder_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_dest   (alloc_dest),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .CDBiscast    (CDBiscast),
        .CDBrobNum    (CDBrobNum),
        .CDBdata      (CDBdata),
        .CDBiscast2   (CDBiscast2),
        .CDBrobNum2   (CDBrobNum2),
        .CDBdata2     (CDBdata2),
        .index        (index),
        .ready        (ready),
        .value        (value),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_dest  (commit_dest),
        .commit_data  (commit_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_commit(input logic [5:0] tag, input logic [4:0] dest, input logic [31:0] data);
        commit_t e;
        e.tag  = tag;
        e.dest = dest;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_alloc(input logic [4:0] dest, input logic [5:0] exp_tag);
        alloc_valid = 1'b1;
        alloc_dest  = dest;
        #1;
        check("alloc_ready", 32'(alloc_ready), 32'd1);
        check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] idx, input logic exp_rdy, input logic [31:0] exp_val);
        index = idx;
        #1;
        check("lookup_ready", 32'(ready), 32'(exp_rdy));
        check("lookup_value", value, exp_val);
    endtask

    // Monitor: every commit pulse must match the oldest expected retirement.
    initial begin
        commit_t e;
        forever begin
            @(negedge clock);
            if (commit_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL commit_unexpected: got tag %0h dest %0h data %0h expected none",
                             commit_tag, commit_dest, commit_data);
                end else begin
                    e = sb.pop_front();
                    check("commit_tag", 32'(commit_tag), 32'(e.tag));
                    check("commit_dest", 32'(commit_dest), 32'(e.dest));
                    check("commit_data", commit_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        alloc_valid = 1'b0;
        alloc_dest  = '0;
        CDBiscast   = 1'b0;
        CDBrobNum   = '0;
        CDBdata     = '0;
        CDBiscast2  = 1'b0;
        CDBrobNum2  = '0;
        CDBdata2    = '0;
        index       = 6'd16;

        repeat (2) tick();
        reset = 1'b0;
        #1;
        // Reset state
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_commit_tag", 32'(commit_tag), 32'd16);
        check("rst_commit_dest", 32'(commit_dest), 32'd0);
        check("rst_commit_data", commit_data, 32'd0);
        tick();

        // Three allocations, then lookup of a pending entry
        do_alloc(5'd1, 6'd0);
        do_alloc(5'd2, 6'd1);
        do_alloc(5'd3, 6'd2);
        lookup(6'd1, 1'b0, 32'd0);

        // Out-of-order completion, in-order retire
        CDBiscast = 1'b1; CDBrobNum = 6'd1; CDBdata = 32'h55;
        tick();
        CDBiscast = 1'b0;
        lookup(6'd1, 1'b1, 32'h55);
        check("no_early_commit", 32'(commit_valid), 32'd0);
        expect_commit(6'd0, 5'd1, 32'h11);
        expect_commit(6'd1, 5'd2, 32'h55);
        CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h11;
        tick();
        CDBiscast = 1'b0;
        check("capture_edge_no_commit", 32'(commit_valid), 32'd0);
        repeat (3) tick();

        expect_commit(6'd2, 5'd3, 32'h22);
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd2; CDBdata2 = 32'h22;
        tick();
        CDBiscast2 = 1'b0;
        repeat (3) tick();

        // Fresh start, fill all 16 entries
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_alloc(5'(i + 10), 6'(i));
        end
        #1;
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_alloc_tag", 32'(alloc_tag), 32'd16);
        alloc_valid = 1'b1; alloc_dest = 5'd31;
        tick();
        alloc_valid = 1'b0;
        check("full_ignored_tag", 32'(alloc_tag), 32'd16);

        // Dual-port collision: port 1 wins
        CDBiscast  = 1'b1; CDBrobNum  = 6'd4; CDBdata  = 32'hAAAA;
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd4; CDBdata2 = 32'hBBBB;
        tick();
        CDBiscast = 1'b0; CDBiscast2 = 1'b0;
        lookup(6'd4, 1'b1, 32'hAAAA);

        // Out-of-range CDB tag is ignored
        CDBiscast = 1'b1; CDBrobNum = 6'd16; CDBdata = 32'hDEAD;
        lookup(6'd16, 1'b0, 32'd0);
        tick();
        CDBiscast = 1'b0;
        lookup(6'd0, 1'b0, 32'd0);

        // Same-cycle lookup vs CDB port 2
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd5; CDBdata2 = 32'h77;
        lookup(6'd5, c_BYPASS, c_BYPASS ? 32'h77 : 32'd0);
        tick();
        CDBiscast2 = 1'b0;
        lookup(6'd5, 1'b1, 32'h77);

        // Full: retire head while alloc is held; alloc refused until count drops
        expect_commit(6'd0, 5'd10, 32'h1234);
        CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h1234;
        alloc_valid = 1'b1; alloc_dest = 5'd7;
        #1;
        check("full_cap_alloc_ready", 32'(alloc_ready), 32'd0);
        tick();
        CDBiscast = 1'b0;
        check("full_commit_alloc_tag", 32'(alloc_tag), 32'd16);
        tick();
        check("wrap_alloc_ready", 32'(alloc_ready), 32'd1);
        check("wrap_alloc_tag", 32'(alloc_tag), 32'd0);
        tick();
        alloc_valid = 1'b0;
        #1;
        check("refill_alloc_ready", 32'(alloc_ready), 32'd0);

        // Complete 1..3; 4 and 5 already done, so five consecutive retires
        expect_commit(6'd1, 5'd11, 32'h101);
        expect_commit(6'd2, 5'd12, 32'h202);
        expect_commit(6'd3, 5'd13, 32'h303);
        expect_commit(6'd4, 5'd14, 32'hAAAA);
        expect_commit(6'd5, 5'd15, 32'h77);
        CDBiscast  = 1'b1; CDBrobNum  = 6'd1; CDBdata  = 32'h101;
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd2; CDBdata2 = 32'h202;
        tick();
        CDBiscast2 = 1'b0;
        CDBrobNum  = 6'd3; CDBdata = 32'h303;
        tick();
        CDBiscast = 1'b0;
        repeat (8) tick();

        // Reset with busy entries and a pending commit
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_alloc(5'(i + 1), 6'(i));
        end
        CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h99;
        tick();
        CDBiscast = 1'b0;
        reset = 1'b1;
        tick();
        check("rst2_commit_valid", 32'(commit_valid), 32'd0);
        check("rst2_commit_tag", 32'(commit_tag), 32'd16);
        check("rst2_alloc_tag", 32'(alloc_tag), 32'd0);
        reset = 1'b0;
        lookup(6'd0, 1'b0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_alloc(5'(i), 6'(i));
        end
        #1;
        check("rst2_full_alloc_ready", 32'(alloc_ready), 32'd0);
        repeat (4) tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
